// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 640x480@60 default timing, pixel type,
// colour-bar table and the stage-1 timing-flag record.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam logic        SYNC_POL_DEF = 1'b0;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [11:0]      rgb12_t;

  // Left-to-right colour bars: white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb12_t BAR_COLOURS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  // Timing flags decoded from one counter state, all active-high
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
    logic ls;
  } vstage_t;

endpackage

// File: rtl/vga_if.sv
// Video bundle between the timing generator (master) and the pixel
// source / display side (slave).
interface vga_if;
  import vga_pkg::*;

  logic   pix_req;
  cnt_t   pix_x;
  cnt_t   pix_y;
  rgb12_t rgb_in;
  logic   test_pattern;
  logic   hsync;
  logic   vsync;
  logic   de;
  rgb12_t rgb_out;
  logic   frame_start;
  logic   line_start;

  modport master (
    output pix_req, pix_x, pix_y, hsync, vsync, de, rgb_out, frame_start, line_start,
    input  rgb_in, test_pattern
  );

  modport slave (
    input  pix_req, pix_x, pix_y, hsync, vsync, de, rgb_out, frame_start, line_start,
    output rgb_in, test_pattern
  );

endinterface

// File: rtl/vga_counter.sv
// Horizontal/vertical raster counters with combinational pixel-request decode.
module vga_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic clk_i,
  input  logic rst_i,
  output cnt_t h_o,
  output cnt_t v_o,
  output logic pix_req_o,
  output cnt_t pix_x_o,
  output cnt_t pix_y_o
);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;

  // h wraps at end of line; v advances on each h wrap and wraps at end of frame
  always_comb begin
    h_d = h_q + cnt_t'(1);
    v_d = v_q;
    if (h_q == cnt_t'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == cnt_t'(V_TOTAL - 1)) ? '0 : v_q + cnt_t'(1);
    end
  end

  // counter state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // request a pixel only inside the visible area; coordinates read 0 outside it
  always_comb begin
    pix_req_o = (h_q < cnt_t'(H_ACTIVE)) && (v_q < cnt_t'(V_ACTIVE));
    pix_x_o   = pix_req_o ? h_q : '0;
    pix_y_o   = pix_req_o ? v_q : '0;
  end

  assign h_o = h_q;
  assign v_o = v_q;

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: raster counters, pixel fetch request, and a
// two-stage registered video pipeline (sync, de, rgb, frame/line pulses).
// Optional built-in colour bars: define VGA_TESTPATTERN_EN.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter logic        SYNC_POL = SYNC_POL_DEF
) (
  input  logic   clk,
  input  logic   reset,
  vga_if.master  vga
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_timing
    $error("vga_timing: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end

  cnt_t h_cnt, v_cnt;

  vga_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL)
  ) u_counter (
    .clk_i     (clk),
    .rst_i     (reset),
    .h_o       (h_cnt),
    .v_o       (v_cnt),
    .pix_req_o (vga.pix_req),
    .pix_x_o   (vga.pix_x),
    .pix_y_o   (vga.pix_y)
  );

  vstage_t s1_d, s1_q;
  rgb12_t  pix_sel;

  // decode the current counter state into timing flags
  always_comb begin
    s1_d.de = vga.pix_req;
    s1_d.hs = (h_cnt >= cnt_t'(HS_START)) && (h_cnt <= cnt_t'(HS_END));
    s1_d.vs = (v_cnt >= cnt_t'(VS_START)) && (v_cnt <= cnt_t'(VS_END));
    s1_d.fs = (h_cnt == '0) && (v_cnt == '0);
    s1_d.ls = (h_cnt == '0) && (v_cnt < cnt_t'(V_ACTIVE));
  end

  // stage 1: timing flags wait here while upstream returns rgb_in
  always_ff @(posedge clk) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

`ifdef VGA_TESTPATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic       tp1_q;
  logic [2:0] bar1_q;

  // pattern select and bar index travel with the stage-1 flags of the same pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      tp1_q  <= 1'b0;
      bar1_q <= '0;
    end else begin
      tp1_q  <= vga.test_pattern;
      bar1_q <= 3'(h_cnt / cnt_t'(BAR_W));
    end
  end

  assign pix_sel = tp1_q ? BAR_COLOURS[bar1_q] : vga.rgb_in;
`else
  assign pix_sel = vga.rgb_in;
`endif

  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   de_q, de_d;
  logic   fs_q, fs_d;
  logic   ls_q, ls_d;
  rgb12_t rgb_q, rgb_d;

  // stage 2 next values: apply sync polarity and blank pixels outside de
  always_comb begin
    hsync_d = s1_q.hs ? SYNC_POL : ~SYNC_POL;
    vsync_d = s1_q.vs ? SYNC_POL : ~SYNC_POL;
    de_d    = s1_q.de;
    fs_d    = s1_q.fs;
    ls_d    = s1_q.ls;
    rgb_d   = s1_q.de ? pix_sel : '0;
  end

  // stage 2: output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.de          = de_q;
  assign vga.frame_start = fs_q;
  assign vga.line_start  = ls_q;
  assign vga.rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing using a reduced raster (50 x 19) so
// several whole frames fit in a short run.
module tb_vga_timing;

  localparam int HA  = 32, HFP = 4, HSW = 8, HBP = 6;
  localparam int VA  = 12, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;   // 50
  localparam int VT  = VA + VFP + VSW + VBP;   // 19
  localparam int FT  = HT * VT;                // 950

`ifdef VGA_TESTPATTERN_EN
  localparam bit TPEN = 1'b1;
`else
  localparam bit TPEN = 1'b0;
`endif

  localparam logic [11:0] BARS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };
  localparam logic [16:0] RST_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_if vif();

  vga_timing #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .SYNC_POL (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected {hsync, vsync, de, frame_start, line_start, rgb_out} for a raster position
  function automatic logic [16:0] model_out(input int s, input bit tp);
    int h, v;
    bit pr, hs_a, vs_a;
    logic [9:0] hx, vy;
    logic [11:0] rgb;
    h    = s % HT;
    v    = s / HT;
    pr   = (h < HA) && (v < VA);
    hs_a = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs_a = (v >= VA + VFP) && (v < VA + VFP + VSW);
    hx   = 10'(h);
    vy   = 10'(v);
    rgb  = {hx[3:0], vy[3:0], 4'hA};
    if (tp && TPEN) rgb = BARS[h / (HA / 8)];
    if (!pr) rgb = '0;
    return {~hs_a, ~vs_a, pr, (h == 0 && v == 0), (h == 0 && v < VA), rgb};
  endfunction

  // Stimulus controls
  bit tp_rand = 1'b0;
  bit tp_fix  = 1'b0;
  bit cap_en  = 1'b0;

  // Upstream pixel source: answers each request one cycle later
  initial begin
    logic [9:0] nx, ny;
    vif.rgb_in       = '0;
    vif.test_pattern = 1'b0;
    forever begin
      @(negedge clk);
      nx = vif.pix_x;
      ny = vif.pix_y;
      @(posedge clk);
      #1;
      vif.rgb_in       = {nx[3:0], ny[3:0], 4'hA};
      vif.test_pattern = tp_rand ? 1'($urandom_range(0, 1)) : tp_fix;
    end
  end

  // Model history: raster index s and reset/test_pattern seen in the last cycles
  int hn = 0;
  int s1 = 0, s2 = 0;
  bit r1, r2, t1, t2;

  // Statistics gathered from DUT outputs
  int fs_q[$], de_q[$], ls_q[$], hfall_q[$], hlow_q[$], vfall_q[$], vlow_q[$];
  int de_cnt = 0, ls_cnt = 0, hlen = 0, vlen = 0;
  bit prev_hs = 1'b1, prev_vs = 1'b1;
  logic [11:0] rgb57;
  bit got57 = 1'b0;
  int cap_idx [4] = '{0, 4, 31, 7 * HT + 5};
  logic [11:0] cap [4];
  bit capd [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  // Compare process: every cycle, counters and registered outputs against the model
  always @(negedge clk) begin
    int s0;
    bit r0, t0, pr;
    logic [16:0] act_o;
    r0 = reset;
    t0 = vif.test_pattern;
    s0 = 0;
    act_o = {vif.hsync, vif.vsync, vif.de, vif.frame_start, vif.line_start, vif.rgb_out};
    if (hn >= 1) begin
      s0 = r1 ? 0 : (s1 + 1) % FT;
      pr = ((s0 % HT) < HA) && ((s0 / HT) < VA);
      check("cycle_pix", {11'd0, vif.pix_req, vif.pix_x, vif.pix_y},
            {11'd0, pr, pr ? 10'(s0 % HT) : 10'd0, pr ? 10'(s0 / HT) : 10'd0});
      if (r1 || (hn >= 2 && r2))
        check("cycle_out_reset", {15'd0, act_o}, {15'd0, RST_OUT});
      else if (hn >= 3)
        check("cycle_out", {15'd0, act_o}, {15'd0, model_out(s2, t2)});

      if (hn >= 3 && !r1 && !r2) begin
        if (!got57 && s2 == 7 * HT + 5) begin
          got57 = 1'b1;
          rgb57 = vif.rgb_out;
        end
        if (cap_en)
          for (int k = 0; k < 4; k++)
            if (!capd[k] && s2 == cap_idx[k]) begin
              capd[k] = 1'b1;
              cap[k]  = vif.rgb_out;
            end
      end

      if (vif.frame_start === 1'b1) begin
        fs_q.push_back(cyc);
        de_q.push_back(de_cnt);
        ls_q.push_back(ls_cnt);
        de_cnt = 0;
        ls_cnt = 0;
      end
      if (vif.de === 1'b1) de_cnt++;
      if (vif.line_start === 1'b1) ls_cnt++;

      if (prev_hs && vif.hsync === 1'b0) begin hfall_q.push_back(cyc); hlen = 0; end
      if (vif.hsync === 1'b0) hlen++;
      if (!prev_hs && vif.hsync === 1'b1) hlow_q.push_back(hlen);
      prev_hs = (vif.hsync === 1'b1);

      if (prev_vs && vif.vsync === 1'b0) begin vfall_q.push_back(cyc); vlen = 0; end
      if (vif.vsync === 1'b0) vlen++;
      if (!prev_vs && vif.vsync === 1'b1) vlow_q.push_back(vlen);
      prev_vs = (vif.vsync === 1'b1);
    end
    s2 = s1; s1 = s0;
    r2 = r1; r1 = r0;
    t2 = t1; t1 = t0;
    hn++;
  end

  // Wait (bounded) for the next frame_start pulse
  task automatic wait_fs(output bit found, output int at);
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      @(negedge clk);
      if (vif.frame_start === 1'b1) begin
        found = 1'b1;
        at    = cyc;
      end
    end
  endtask

  initial begin
    int rel, fs_at, bad;
    bit found;
    logic [11:0] exp_cap [4];

    // Reset state
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_pix", {11'd0, vif.pix_req, vif.pix_x, vif.pix_y}, {11'd0, 1'b1, 20'd0});
    check("reset_out", {15'd0, vif.hsync, vif.vsync, vif.de, vif.frame_start,
                        vif.line_start, vif.rgb_out}, {15'd0, RST_OUT});

    // Release: frame_start exactly two cycles later
    reset = 1'b0;
    rel = cyc;
    wait_fs(found, fs_at);
    check("first_frame_start_delay", found ? fs_at - rel : -1, 2);

    // Two full frames of plain video
    repeat (2 * FT + 60) @(posedge clk);
    #1;
    check("frames_seen", fs_q.size() >= 3, 1);
    if (fs_q.size() >= 3) begin
      check("frame_period_1", fs_q[1] - fs_q[0], 950);
      check("frame_period_2", fs_q[2] - fs_q[1], 950);
      check("de_per_frame_1", de_q[1], 384);
      check("de_per_frame_2", de_q[2], 384);
      check("line_start_per_frame_1", ls_q[1], 12);
      check("line_start_per_frame_2", ls_q[2], 12);
    end
    check("hsync_edges_seen", hfall_q.size() >= 2 && hlow_q.size() >= 38, 1);
    if (hfall_q.size() >= 2 && fs_q.size() >= 1) begin
      check("hsync_first_fall", hfall_q[0] - fs_q[0], 36);
      check("hsync_period", hfall_q[1] - hfall_q[0], 50);
    end
    bad = 0;
    for (int i = 0; i < 38 && i < hlow_q.size(); i++)
      if (hlow_q[i] != 8) bad++;
    check("hsync_low_width_all", bad, 0);
    check("vsync_edges_seen", vfall_q.size() >= 1 && vlow_q.size() >= 1, 1);
    if (vfall_q.size() >= 1 && vlow_q.size() >= 1 && fs_q.size() >= 1) begin
      check("vsync_first_fall", vfall_q[0] - fs_q[0], 700);
      check("vsync_low_width", vlow_q[0], 100);
    end
    check("rgb_x5_y7", got57 ? {20'd0, rgb57} : 32'hDEAD, 32'h57A);

    // Mid-frame reset at (20,5) held for three cycles
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      @(negedge clk);
      if (vif.pix_x == 10'd20 && vif.pix_y == 10'd5) found = 1'b1;
    end
    check("midframe_reached", found, 1);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    tp_fix = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midreset_out", {15'd0, vif.hsync, vif.vsync, vif.de, vif.frame_start,
                           vif.line_start, vif.rgb_out}, {15'd0, RST_OUT});
    check("midreset_pix", {11'd0, vif.pix_req, vif.pix_x, vif.pix_y}, {11'd0, 1'b1, 20'd0});
    @(posedge clk);
    #1;
    reset  = 1'b0;
    rel    = cyc;
    cap_en = 1'b1;
    wait_fs(found, fs_at);
    check("midreset_frame_start_delay", found ? fs_at - rel : -1, 2);

    // Frame with test_pattern held high
    repeat (FT + 20) @(posedge clk);
    #1;
    if (TPEN) exp_cap = '{12'hFFF, 12'hFF0, 12'h000, 12'hFF0};
    else      exp_cap = '{12'h00A, 12'h40A, 12'hF0A, 12'h57A};
    for (int k = 0; k < 4; k++)
      check($sformatf("tp_hold_x%0d", cap_idx[k]),
            capd[k] ? {20'd0, cap[k]} : 32'hDEAD, {20'd0, exp_cap[k]});

    // Frame with test_pattern toggling per pixel
    cap_en  = 1'b0;
    tp_rand = 1'b1;
    repeat (FT + 20) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
